byte_xor_unit: RTL and testbench

- Conditional byte inverter for the CPU datapath ALU/complement path. Each bit of the input byte is XORed with the enable bit: when en=1 the output is the one's complement of the input, and when en=0 the input passes through unchanged.
- The result is registered, with a one-cycle latency.
- Status outputs (zero, parity, valid) are provided for the flag logic.

---
 rtl/byte_xor_unit.sv | 58 +++++
 tb/tb_byte_xor_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_xor_unit.sv
// Conditional byte inverter: registers a ^ {WIDTH{en}} with zero/parity flags.
// One-cycle latency, one operand per cycle; all outputs come straight from flops.
module byte_xor_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             en,
    input  logic             in_valid,
    output logic [WIDTH-1:0] o,
    output logic             out_valid,
    output logic             zero,
    output logic             parity
);

    logic [WIDTH-1:0] o_q, o_d;
    logic             valid_q, valid_d;
    logic             zero_q, zero_d;
    logic             parity_q, parity_d;
    logic [WIDTH-1:0] result;

    assign result = a ^ {WIDTH{en}};

    // Idle cycles hold the result and flags so X on a/en cannot reach the flops.
    always_comb begin
        o_d      = o_q;
        zero_d   = zero_q;
        parity_d = parity_q;
        valid_d  = 1'b0;
        if (in_valid) begin
            o_d      = result;
            zero_d   = (result == '0);
            parity_d = ^result;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_q      <= '0;
            valid_q  <= 1'b0;
            zero_q   <= 1'b1;
            parity_q <= 1'b0;
        end else begin
            o_q      <= o_d;
            valid_q  <= valid_d;
            zero_q   <= zero_d;
            parity_q <= parity_d;
        end
    end

    assign o         = o_q;
    assign out_valid = valid_q;
    assign zero      = zero_q;
    assign parity    = parity_q;

endmodule

// File: tb/tb_byte_xor_unit.sv
// Self-checking bench for byte_xor_unit: directed scenarios plus a random
// regression, with expected results queued at drive time and popped after the edge.
module tb_byte_xor_unit;

    typedef struct packed {
        logic [7:0] o;
        logic       v;
        logic       z;
        logic       p;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic       en;
    logic       in_valid;
    logic [7:0] o;
    logic       out_valid;
    logic       zero;
    logic       parity;

    exp_t sb[$];
    exp_t exp_v;
    exp_t got;
    int   checks;
    int   errors;

    // Reference model state
    logic [7:0] m_o;
    logic       m_v;
    logic       m_z;
    logic       m_p;

    byte_xor_unit #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .en       (en),
        .in_valid (in_valid),
        .o        (o),
        .out_valid(out_valid),
        .zero     (zero),
        .parity   (parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign got = '{o: o, v: out_valid, z: zero, p: parity};

    // Drive one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic cycle(input logic r, input logic iv, input logic [7:0] av, input logic ev);
        logic [7:0] res;
        rst      = r;
        in_valid = iv;
        a        = av;
        en       = ev;
        res      = av ^ {8{ev}};
        if (r) begin
            m_o = 8'h00; m_v = 1'b0; m_z = 1'b1; m_p = 1'b0;
        end else if (iv) begin
            m_o = res; m_v = 1'b1; m_z = (res == 8'h00); m_p = ^res;
        end else begin
            m_v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{o: 8'h00, v: 1'b0, z: 1'b1, p: 1'b0});
            cycle(1'b1, 1'b1, 8'hAA, 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reset[%0d]: got o=%h v=%b z=%b p=%b, want o=%h v=%b z=%b p=%b",
                         i, got.o, got.v, got.z, got.p, exp_v.o, exp_v.v, exp_v.z, exp_v.p);
            end
        end
    endtask

    task automatic test_complement_ones();
        sb.push_back('{o: 8'h00, v: 1'b1, z: 1'b1, p: 1'b0});
        cycle(1'b0, 1'b1, 8'hFF, 1'b1);
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL complement_ones: got o=%h v=%b z=%b p=%b, want o=%h v=%b z=%b p=%b",
                     got.o, got.v, got.z, got.p, exp_v.o, exp_v.v, exp_v.z, exp_v.p);
        end
    endtask

    task automatic test_pass_through();
        logic [7:0] av [2] = '{8'h9D, 8'h00};
        sb.push_back('{o: 8'h9D, v: 1'b1, z: 1'b0, p: 1'b1});
        sb.push_back('{o: 8'h00, v: 1'b1, z: 1'b1, p: 1'b0});
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1, av[i], 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL pass_through[%0d]: got o=%h v=%b z=%b p=%b, want o=%h v=%b z=%b p=%b",
                         i, got.o, got.v, got.z, got.p, exp_v.o, exp_v.v, exp_v.z, exp_v.p);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] av [2] = '{8'hC6, 8'hF0};
        sb.push_back('{o: 8'h39, v: 1'b1, z: 1'b0, p: 1'b0});
        sb.push_back('{o: 8'h0F, v: 1'b1, z: 1'b0, p: 1'b0});
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1, av[i], 1'b1);
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got o=%h v=%b z=%b p=%b, want o=%h v=%b z=%b p=%b",
                         i, got.o, got.v, got.z, got.p, exp_v.o, exp_v.v, exp_v.z, exp_v.p);
            end
        end
    endtask

    // Idle cycles, including en toggling alone and X on a/en, must hold o.
    task automatic test_hold();
        logic [7:0] av [4] = '{8'h55, 8'h55, 8'h55, 8'hxx};
        logic       ev [4] = '{1'b1, 1'b1, 1'b0, 1'bx};
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{o: 8'h0F, v: 1'b0, z: 1'b0, p: 1'b0});
            cycle(1'b0, 1'b0, av[i], ev[i]);
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL hold[%0d]: got o=%h v=%b z=%b p=%b, want o=%h v=%b z=%b p=%b",
                         i, got.o, got.v, got.z, got.p, exp_v.o, exp_v.v, exp_v.z, exp_v.p);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic       rv [3] = '{1'b0, 1'b1, 1'b0};
        logic       iv [3] = '{1'b1, 1'b1, 1'b0};
        logic [7:0] av [3] = '{8'h12, 8'h3C, 8'h3C};
        logic       ev [3] = '{1'b0, 1'b1, 1'b1};
        sb.push_back('{o: 8'h12, v: 1'b1, z: 1'b0, p: 1'b0});
        sb.push_back('{o: 8'h00, v: 1'b0, z: 1'b1, p: 1'b0});
        sb.push_back('{o: 8'h00, v: 1'b0, z: 1'b1, p: 1'b0});
        for (int i = 0; i < 3; i++) begin
            cycle(rv[i], iv[i], av[i], ev[i]);
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reset_midstream[%0d]: got o=%h v=%b z=%b p=%b, want o=%h v=%b z=%b p=%b",
                         i, got.o, got.v, got.z, got.p, exp_v.o, exp_v.v, exp_v.z, exp_v.p);
            end
        end
    endtask

    task automatic test_random();
        logic       r;
        logic       iv;
        logic [7:0] av;
        logic       ev;
        for (int i = 0; i < 1000; i++) begin
            r  = ($urandom_range(0, 31) == 0);
            iv = ($urandom_range(0, 3) != 0);
            av = 8'($urandom);
            ev = 1'($urandom);
            cycle(r, iv, av, ev);
            sb.push_back('{o: m_o, v: m_v, z: m_z, p: m_p});
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL random[%0d]: got o=%h v=%b z=%b p=%b, want o=%h v=%b z=%b p=%b",
                         i, got.o, got.v, got.z, got.p, exp_v.o, exp_v.v, exp_v.z, exp_v.p);
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        a        = 8'h00;
        en       = 1'b0;
        in_valid = 1'b0;
        m_o = 8'h00; m_v = 1'b0; m_z = 1'b1; m_p = 1'b0;
        #2;
        test_reset();
        test_complement_ones();
        test_pass_through();
        test_back_to_back();
        test_hold();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
